imem_loader: RTL and testbench

- Boot-time loader upstream of the single-cycle processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words into the instruction memory write port, verifies an XOR checksum, and holds the processor in reset until a load completes cleanly.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and frame field widths.
package imem_loader_pkg;

   localparam int CNT_WIDTH  = 16;
   localparam int BYTE_WIDTH = 8;
   localparam int WORD_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_WORD,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes MSB first into a 32-bit word and flags the byte that completes it.
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [BYTE_WIDTH-1:0] byte_in,
   output logic [WORD_WIDTH-1:0] word,
   output logic                  complete
);

   logic [1:0]  byte_cnt;
   logic [23:0] shift;

   // The completing byte is merged combinationally so the word is ready on its own transfer edge.
   assign word     = {shift, byte_in};
   assign complete = load && (byte_cnt == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt <= '0;
         shift    <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
         shift    <= '0;
      end else if (load) begin
         byte_cnt <= byte_cnt + 2'd1;
         shift    <= {shift[15:0], byte_in};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte frame, writes instruction words, verifies the XOR checksum
// and releases the processor reset only after a clean load.
//
// state    | meaning
// IDLE     | waiting for CNT_HI
// CNT_LO   | waiting for CNT_LO, then range-check the word count
// WORD     | receiving payload bytes, one write per 4 bytes
// CHECK    | waiting for the checksum byte
// DONE     | load good, processor released, wait for start
// ERROR    | load failed, wait for start
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   input  logic                  start,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int WL       = ADDR_WIDTH + 1;
   localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CAPACITY = 2 ** ADDR_WIDTH;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic [BYTE_WIDTH-1:0]   cnt_hi;
   logic [BYTE_WIDTH-1:0]   chk;
   logic [WL-1:0]           words_total;
   logic [TW-1:0]           to_cnt;
   logic                    accept;
   logic [CNT_WIDTH-1:0]    count;
   logic [WORD_WIDTH-1:0]   asm_word;
   logic                    asm_complete;

   assign rx_ready = !reset && (state inside {S_IDLE, S_CNT_LO, S_WORD, S_CHECK});
   assign accept   = rx_valid && rx_ready;
   assign count    = {cnt_hi, rx_data};

   imem_loader_word_assembler u_asm (
      .clk      (clk),
      .reset    (reset),
      .clear    (state != S_WORD),
      .load     (accept && (state == S_WORD)),
      .byte_in  (rx_data),
      .word     (asm_word),
      .complete (asm_complete)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt_hi       <= '0;
         chk          <= '0;
         words_total  <= '0;
         to_cnt       <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         words_loaded <= '0;
         cpu_reset    <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (accept) begin
            to_cnt <= '0;
         end else if (state inside {S_CNT_LO, S_WORD, S_CHECK}) begin
            if (to_cnt == TO_LAST) begin
               state <= S_ERROR;
               error <= 1'b1;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end

         case (state)
            S_IDLE: if (accept) begin
               cnt_hi <= rx_data;
               chk    <= rx_data;
               state  <= S_CNT_LO;
            end
            S_CNT_LO: if (accept) begin
               chk         <= chk ^ rx_data;
               words_total <= WL'(count);
               if (int'(count) > CAPACITY) begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end else if (count == '0) begin
                  state <= S_CHECK;
               end else begin
                  state <= S_WORD;
               end
            end
            S_WORD: if (accept) begin
               chk <= chk ^ rx_data;
               if (asm_complete) begin
                  wr_en        <= 1'b1;
                  wr_data      <= asm_word;
                  wr_addr      <= words_loaded[ADDR_WIDTH-1:0];
                  words_loaded <= words_loaded + WL'(1);
                  if (words_loaded + WL'(1) == words_total) state <= S_CHECK;
               end
            end
            S_CHECK: if (accept) begin
               if (rx_data == chk) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  state <= S_ERROR;
                  error <= 1'b1;
               end
            end
            S_DONE, S_ERROR: if (start) begin
               state        <= S_IDLE;
               done         <= 1'b0;
               error        <= 1'b0;
               cpu_reset    <= 1'b1;
               words_loaded <= '0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard fed by the frame sender.
module tb_imem_loader;

   localparam int AW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          start;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          cpu_reset;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   int checks   = 0;
   int failures = 0;

   logic [39:0] exp_q[$];
   logic [31:0] words[$];

   imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .start        (start),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_reset    (cpu_reset),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(wr_en), 32'd0);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[39:32]));
            check("wr_data", wr_data, e[31:0]);
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   function automatic int pick_gap(input bit rnd);
      if (!rnd) return 0;
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return 1;
         2:       return TO - 1;
         default: return 2;
      endcase
   endfunction

   // Gap cycles may carry a start pulse, which a loading DUT must ignore.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int gap;
      bit poke;
      gap  = pick_gap(rnd);
      poke = rnd && ($urandom_range(0, 2) == 0);
      for (int i = 0; i < gap; i++) begin
         start = poke && (i == 0);
         tick(1);
         start = 1'b0;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] n, input logic [7:0] chk_flip, input bit rnd);
      logic [7:0] chk;
      logic [7:0] b;
      chk = n[15:8] ^ n[7:0];
      send_byte(n[15:8], rnd);
      send_byte(n[7:0], rnd);
      for (int w = 0; w < int'(n); w++) begin
         for (int k = 0; k < 4; k++) begin
            b   = words[w][31-8*k -: 8];
            chk = chk ^ b;
            if (k == 3) exp_q.push_back({8'(w), words[w]});
            send_byte(b, rnd);
         end
      end
      send_byte(chk ^ chk_flip, rnd);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      start    = 1'b0;
      tick(2);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      reset = 1'b0;
      #1;
      check("idle_rx_ready", 32'(rx_ready), 32'd1);

      // Good two-word frame, back to back
      words = '{32'h2008_0005, 32'h8C09_0000};
      send_frame(16'd2, 8'h00, 1'b0);
      check("good_done", 32'(done), 32'd1);
      check("good_error", 32'(error), 32'd0);
      check("good_cpu_reset", 32'(cpu_reset), 32'd0);
      check("good_words", 32'(words_loaded), 32'd2);
      check("good_rx_ready", 32'(rx_ready), 32'd0);
      check("good_pending", 32'(exp_q.size()), 32'd0);

      // start wins over a byte offered in DONE; afterwards IDLE never times out
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h00;
      tick(1);
      start    = 1'b0;
      rx_valid = 1'b0;
      check("rearm_done", 32'(done), 32'd0);
      check("rearm_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rearm_words", 32'(words_loaded), 32'd0);
      tick(TO + 4);
      check("idle_no_timeout", 32'(error), 32'd0);

      // Bad checksum: words still written, then ERROR
      send_frame(16'd2, 8'hFF, 1'b0);
      check("badchk_error", 32'(error), 32'd1);
      check("badchk_done", 32'(done), 32'd0);
      check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
      check("badchk_words", 32'(words_loaded), 32'd2);
      check("badchk_pending", 32'(exp_q.size()), 32'd0);
      pulse_start();
      check("badchk_rearm_error", 32'(error), 32'd0);
      check("badchk_rearm_ready", 32'(rx_ready), 32'd1);

      // Count beyond capacity
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_rx_ready", 32'(rx_ready), 32'd0);
      check("ovf_words", 32'(words_loaded), 32'd0);
      pulse_start();

      // Empty frame
      send_frame(16'd0, 8'h00, 1'b0);
      check("empty_done", 32'(done), 32'd1);
      check("empty_words", 32'(words_loaded), 32'd0);
      pulse_start();

      // Timeout mid-word: TO-1 idle cycles survive, TO idle cycles fail
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h20, 1'b0);
      tick(TO - 1);
      check("to_before", 32'(error), 32'd0);
      tick(1);
      check("to_error", 32'(error), 32'd1);
      check("to_words", 32'(words_loaded), 32'd0);
      pulse_start();

      // Reset mid-word, then a fresh one-word frame
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      reset = 1'b1;
      #2;
      check("midrst_rx_ready", 32'(rx_ready), 32'd0);
      check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("midrst_words", 32'(words_loaded), 32'd0);
      tick(1);
      reset = 1'b0;
      words = '{32'h1122_3344};
      send_frame(16'd1, 8'h00, 1'b0);
      check("midrst_done", 32'(done), 32'd1);
      check("midrst_words_after", 32'(words_loaded), 32'd1);
      check("midrst_pending", 32'(exp_q.size()), 32'd0);
      pulse_start();

      // Random gaps with start pokes
      words = '{32'h2008_0005, 32'h8C09_0000};
      send_frame(16'd2, 8'h00, 1'b1);
      check("gap_done", 32'(done), 32'd1);
      check("gap_words", 32'(words_loaded), 32'd2);
      check("gap_pending", 32'(exp_q.size()), 32'd0);
      pulse_start();
      words = '{$urandom(), $urandom(), $urandom()};
      send_frame(16'd3, 8'h00, 1'b1);
      check("gap3_done", 32'(done), 32'd1);
      check("gap3_words", 32'(words_loaded), 32'd3);
      check("gap3_pending", 32'(exp_q.size()), 32'd0);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
